// File: rtl/asic_mem_responder.sv
// Single-port 64-bit word memory behind a request/response handshake.
// One request outstanding at a time; response arrives a fixed LATENCY cycles after acceptance.
module asic_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_ready_o,
  input  logic        mem_req_valid_i,
  input  logic [39:0] mem_req_addr_i,
  input  logic [4:0]  mem_req_cmd_i,
  input  logic [2:0]  mem_req_typ_i,
  input  logic [63:0] mem_req_data_i,
  output logic        mem_resp_valid_o,
  output logic [39:0] mem_resp_addr_o,
  output logic [4:0]  mem_resp_cmd_o,
  output logic [2:0]  mem_resp_typ_o,
  output logic [63:0] mem_resp_data_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [63:0]        req_data;
  logic [63:0]        mem [DEPTH_WORDS];

  logic               accept;
  logic               fire;
  logic               is_load;
  logic               is_store;
  logic [39:0]        op_addr;
  logic [4:0]         op_cmd;
  logic [2:0]         op_typ;
  logic [63:0]        op_data;
  logic [IDX_W-1:0]   idx;
  logic [2:0]         off;
  logic [5:0]         sh;
  logic [7:0]         smask;
  logic [7:0]         bmask;
  logic [63:0]        old_word;
  logic [63:0]        wshift;
  logic [63:0]        merged;
  logic [63:0]        raw;
  logic [63:0]        load_val;
  logic [63:0]        resp_val;

  assign accept = mem_req_valid_i && mem_req_ready_o;

  // The operation is committed on the edge entering RESP; with LATENCY 1 that is the
  // acceptance edge itself, so the live inputs are used instead of the captured copy.
  always_comb begin
    if (state == IDLE) begin
      op_addr = mem_req_addr_i;
      op_cmd  = mem_req_cmd_i;
      op_typ  = mem_req_typ_i;
      op_data = mem_req_data_i;
    end else begin
      op_addr = mem_resp_addr_o;
      op_cmd  = mem_resp_cmd_o;
      op_typ  = mem_resp_typ_o;
      op_data = req_data;
    end
  end

  always_comb begin
    if (LATENCY == 1) fire = (state == IDLE) && accept;
    else              fire = (state == BUSY) && (cnt == CNT_W'(1));
  end

  assign is_load  = (op_cmd == 5'd0);
  assign is_store = (op_cmd == 5'd1);

  // Address decode: word index wraps, byte offset aligns down to the access size.
  always_comb begin
    idx = op_addr[3 +: IDX_W];
    case (op_typ[1:0])
      2'd0:    begin off = op_addr[2:0];           smask = 8'h01; end
      2'd1:    begin off = {op_addr[2:1], 1'b0};   smask = 8'h03; end
      2'd2:    begin off = {op_addr[2], 2'b00};    smask = 8'h0F; end
      default: begin off = 3'b000;                 smask = 8'hFF; end
    endcase
    sh       = {off, 3'b000};
    bmask    = smask << off;
    old_word = mem[idx];
  end

  // Store merge: only the addressed bytes take new data.
  always_comb begin
    wshift = op_data << sh;
    merged = old_word;
    for (int i = 0; i < 8; i++) begin
      if (bmask[i]) merged[8*i +: 8] = wshift[8*i +: 8];
    end
  end

  // Load extract with sign or zero extension.
  always_comb begin
    raw = old_word >> sh;
    case (op_typ[1:0])
      2'd0:    load_val = op_typ[2] ? 64'(raw[7:0])  : {{56{raw[7]}},  raw[7:0]};
      2'd1:    load_val = op_typ[2] ? 64'(raw[15:0]) : {{48{raw[15]}}, raw[15:0]};
      2'd2:    load_val = op_typ[2] ? 64'(raw[31:0]) : {{32{raw[31]}}, raw[31:0]};
      default: load_val = raw;
    endcase
    resp_val = is_load ? load_val : 64'd0;
  end

  // Memory array has no reset; contents persist across reset.
  always_ff @(posedge clk) begin
    if (fire && is_store) mem[idx] <= merged;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      req_data         <= '0;
      mem_req_ready_o  <= 1'b0;
      mem_resp_valid_o <= 1'b0;
      mem_resp_addr_o  <= '0;
      mem_resp_cmd_o   <= '0;
      mem_resp_typ_o   <= '0;
      mem_resp_data_o  <= '0;
    end else begin
      mem_resp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          mem_req_ready_o <= 1'b1;
          if (accept) begin
            mem_req_ready_o <= 1'b0;
            mem_resp_addr_o <= mem_req_addr_i;
            mem_resp_cmd_o  <= mem_req_cmd_i;
            mem_resp_typ_o  <= mem_req_typ_i;
            req_data        <= mem_req_data_i;
            if (LATENCY == 1) begin
              state            <= RESP;
              mem_resp_valid_o <= 1'b1;
              mem_resp_data_o  <= resp_val;
            end else begin
              state <= BUSY;
              cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          mem_req_ready_o <= 1'b0;
          cnt             <= cnt - CNT_W'(1);
          if (fire) begin
            state            <= RESP;
            mem_resp_valid_o <= 1'b1;
            mem_resp_data_o  <= resp_val;
          end
        end
        RESP: begin
          state           <= IDLE;
          mem_req_ready_o <= 1'b1;
        end
        default: begin
          state           <= IDLE;
          mem_req_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
